// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD display path.
// Contents: FSM state enum, active-low segment patterns {g,f,e,d,c,b,a},
// and the per-nibble double-dabble correction function.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Pre-shift correction: a digit >= 5 would become >= 10 after doubling.
  // Legal inputs are 0..9, so the 4-bit sum never wraps.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
  endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// One BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Ports: bcd (digit 0..9), blank (force all segments off), seg_c (combinational pattern).
// Codes 10..15 cannot be produced upstream and decode to all-off.
module bcd_to_seven_seg
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/binary_bcd_seq_display.sv
// Sequential double-dabble binary-to-BCD converter with registered seven-segment outputs.
// Ports: clk, reset (sync, active-high), start/bin_in (request + operand),
//        busy (conversion running), done (1-cycle pulse, results already valid),
//        bcd_out (packed BCD, digit 0 lowest), hex_out (active-low segments, digit 0 lowest).
module binary_bcd_seq_display
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DIGITS        = 3,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SEG_W = 7 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + WIDTH;
  localparam int unsigned CNT_W = (WIDTH + 1 > 1) ? $clog2(WIDTH + 1) : 1;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Digit 0 shows '0'; upper digits follow the blanking policy for an all-zero value.
  function automatic logic [SEG_W-1:0] hex_reset_value();
    logic [SEG_W-1:0] h;
    h = '0;
    for (int unsigned d = 0; d < DIGITS; d++)
      h[7*d +: 7] = (d != 0 && BLANK_LEADING) ? SEG_BLANK : SEG_0;
    return h;
  endfunction

  localparam logic [SEG_W-1:0] HEX_RST = hex_reset_value();

  if (WIDTH < 1 || pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_param
    $error("binary_bcd_seq_display: DIGITS too small for WIDTH, or WIDTH < 1");
  end

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d, done_d;
  logic [BCD_W-1:0]   bcd_d;
  logic [SEG_W-1:0]   hex_d;

  logic [SR_W-1:0]    shifted_c;
  logic [BCD_W-1:0]   res_bcd_c;
  logic [DIGITS-1:0]  blank_c;
  logic [SEG_W-1:0]   seg_c;

  // One double-dabble step: correct every BCD nibble, then shift the whole register left.
  always_comb begin
    logic [SR_W-1:0] adj;
    adj = sr_q;
    for (int unsigned d = 0; d < DIGITS; d++)
      adj[WIDTH + 4*d +: 4] = add3_if_ge5(sr_q[WIDTH + 4*d +: 4]);
    shifted_c = {adj[SR_W-2:0], 1'b0};
  end

  assign res_bcd_c = shifted_c[SR_W-1 -: BCD_W];

  // Digit k > 0 is blanked when it and every digit above it are zero.
  assign blank_c[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_blank
    assign blank_c[k] = BLANK_LEADING && (res_bcd_c[BCD_W-1:4*k] == '0);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_to_seven_seg u_dec (
      .bcd   (res_bcd_c[4*g +: 4]),
      .blank (blank_c[g]),
      .seg_c (seg_c[7*g +: 7])
    );
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bcd_d   = bcd_out;
    hex_d   = hex_out;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, bin_in};
          cnt_d   = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sr_d   = shifted_c;
        cnt_d  = CNT_W'(cnt_q + 1'b1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = res_bcd_c;
          hex_d   = seg_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      hex_out <= HEX_RST;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      bcd_out <= bcd_d;
      hex_out <= hex_d;
    end
  end

endmodule
